reg_wb_scheduler: RTL and testbench
===================================

Name: reg_wb_scheduler

Overview:
- Shares the register file's single write port between two writeback sources: A, the single-cycle ALU pipe, and B, a long-latency mul/div/load unit.
- Keeps a per-register busy scoreboard for long operations that are still outstanding.
- Stalls instruction issue on RAW/WAW hazards against busy registers, on outstanding-count overflow, and when B is starved.
- Sits between the pipeline writeback stage and the register file write port (RegWrite/RDaddr/RDdata).

Parameters:
MAX_OUT, 4, maximum outstanding long operations (1..31)
CNT_W, 3, width of outstanding counter (must hold MAX_OUT)
STARVE_LIMIT, 8, cycles B may wait unserved before issue is frozen
WAIT_W, 4, width of B wait counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
a_valid_i  in  1  ALU writeback valid; always accepted
a_addr_i  in  5  ALU destination register
a_data_i  in  32  ALU writeback data
b_valid_i  in  1  long-unit writeback valid
b_addr_i  in  5  long-unit destination register
b_data_i  in  32  long-unit writeback data
b_ready_o  out  1  long-unit writeback accepted this cycle
issue_valid_i  in  1  decode stage presents an instruction
issue_rs_i  in  5  source register 1
issue_rt_i  in  5  source register 2
issue_rd_i  in  5  destination register
issue_long_i  in  1  instruction is a long-latency op
stall_o  out  1  hold decode; issue not accepted
RegWrite_o  out  1  register file write enable
RDaddr_o  out  5  register file write address
RDdata_o  out  32  register file write data
outstanding_o  out  CNT_W  current outstanding long-op count

Behaviour:
- Reset (rst_i=0, asynchronous): busy[31:0]=0, outstanding=0, wait_cnt=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0. Because b_ready_o and stall_o are combinational, during reset b_ready_o=!a_valid_i and stall_o=0. Reset during a pending B write drops that write.
- Arbitration: A has fixed priority. b_ready_o = !a_valid_i (combinational). B is accepted when b_valid_i & b_ready_o.
- Write port latency is 1 cycle, registered. At each edge:
  - If a_valid_i: RegWrite_o<=(a_addr_i!=0), RDaddr_o<=a_addr_i, RDdata_o<=a_data_i.
  - Else if B accepted: RegWrite_o<=(b_addr_i!=0), RDaddr_o<=b_addr_i, RDdata_o<=b_data_i.
  - Else: RegWrite_o<=0; addr and data hold their previous values.
- Writes to $0 never assert RegWrite_o.
- Stall (combinational) = issue_valid_i & ( busy[rs] | busy[rt] | busy[rd] | (issue_long_i & outstanding==MAX_OUT) | starve ).
  - busy[0] is hard-wired to 0.
  - busy is the registered value; there is no same-cycle bypass of a B clear.
- Issue accepted = issue_valid_i & !stall_o. On an accepted long issue: outstanding+1, and busy[rd]<=1 if rd!=0. Long ops with rd=0 still count as outstanding.
- On B accept: busy[b_addr]<=0, outstanding-1.
- Simultaneous events:
  - Accepted long issue and B accept to the same register: busy ends at 1, because the set wins.
  - Long issue and B accept in the same cycle: outstanding is unchanged.
- Starvation:
  - wait_cnt increments (saturating) each cycle b_valid_i & !b_ready_o.
  - wait_cnt clears on B accept or when !b_valid_i.
  - starve = (wait_cnt >= STARVE_LIMIT). starve freezes all issue, so the A pipe drains and B is served.
- Illegal conditions (a bench assertion flags them; the design does not correct them): B accept when outstanding==0; B accept for a non-busy nonzero register.
- outstanding_o is a direct register output.

Test Plan:
1. Reset, then A writes r5=0x1234 -> next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0x1234; b_ready_o=0 during the A cycle.
2. Long issue rd=8; next cycle issue rs=8 -> stall_o=1. Then B returns r8=0xBEEF with a_valid_i=0 -> b_ready_o=1, write appears 1 cycle later; the following cycle the rs=8 issue is accepted with stall_o=0.
3. Four long issues (r1..r4) with MAX_OUT=4; fifth long issue (rd=9) -> stall_o=1, outstanding_o=4. A non-long issue using r10 is still accepted.
4. a_valid_i held high while b_valid_i high for 8 cycles -> starve asserted on cycle 9; every issue_valid_i gives stall_o=1 until a_valid_i drops and B is accepted; wait_cnt returns to 0.
5. Same cycle: B accept r7 and long issue rd=7 -> busy[7] stays 1, outstanding unchanged. A write to r0 -> RegWrite_o stays 0.
6. Assert rst_i=0 mid-stream with busy bits set and B pending -> all outputs and busy clear immediately; after release, an issue on the previously busy register gives stall_o=0.

Source files
------------

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port arbiter for the ALU pipe (A) and the long-latency unit (B),
// with a busy scoreboard for outstanding long ops and issue stall generation.
module reg_wb_scheduler #(
    parameter int unsigned MAX_OUT      = 4,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned WAIT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_valid_i,
    input  logic [4:0]       a_addr_i,
    input  logic [31:0]      a_data_i,
    input  logic             b_valid_i,
    input  logic [4:0]       b_addr_i,
    input  logic [31:0]      b_data_i,
    output logic             b_ready_o,
    input  logic             issue_valid_i,
    input  logic [4:0]       issue_rs_i,
    input  logic [4:0]       issue_rt_i,
    input  logic [4:0]       issue_rd_i,
    input  logic             issue_long_i,
    output logic             stall_o,
    output logic             RegWrite_o,
    output logic [4:0]       RDaddr_o,
    output logic [31:0]      RDdata_o,
    output logic [CNT_W-1:0] outstanding_o
);

    logic [31:0]       busy;
    logic [31:0]       busy_next;
    logic [CNT_W-1:0]  outstanding;
    logic [WAIT_W-1:0] wait_cnt;
    logic              b_accept;
    logic              starve;
    logic              full;
    logic              hazard;
    logic              issue_accept;
    logic              long_accept;

    // A always wins the write port; B only gets it on cycles A is idle.
    assign b_ready_o = !a_valid_i;
    assign b_accept  = b_valid_i & !a_valid_i;

    assign starve = (wait_cnt >= WAIT_W'(STARVE_LIMIT));
    assign full   = (outstanding == CNT_W'(MAX_OUT));
    assign hazard = busy[issue_rs_i] | busy[issue_rt_i] | busy[issue_rd_i];

    assign stall_o      = issue_valid_i & (hazard | (issue_long_i & full) | starve);
    assign issue_accept = issue_valid_i & !stall_o;
    assign long_accept  = issue_accept & issue_long_i;

    assign outstanding_o = outstanding;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (b_accept) begin
            busy_next[b_addr_i] = 1'b0;
        end
        if (long_accept) begin
            busy_next[issue_rd_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            outstanding <= '0;
        end else begin
            unique case ({long_accept, b_accept})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (!b_valid_i || b_accept) begin
            wait_cnt <= '0;
        end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else if (a_valid_i) begin
            RegWrite_o <= (a_addr_i != 5'd0);
            RDaddr_o   <= a_addr_i;
            RDdata_o   <= a_data_i;
        end else if (b_accept) begin
            RegWrite_o <= (b_addr_i != 5'd0);
            RDaddr_o   <= b_addr_i;
            RDdata_o   <= b_data_i;
        end else begin
            RegWrite_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed self-checking bench for reg_wb_scheduler; inputs change on the falling edge.
module tb_reg_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_valid_i;
    logic [4:0]  a_addr_i;
    logic [31:0] a_data_i;
    logic        b_valid_i;
    logic [4:0]  b_addr_i;
    logic [31:0] b_data_i;
    logic        b_ready_o;
    logic        issue_valid_i;
    logic [4:0]  issue_rs_i;
    logic [4:0]  issue_rt_i;
    logic [4:0]  issue_rd_i;
    logic        issue_long_i;
    logic        stall_o;
    logic        RegWrite_o;
    logic [4:0]  RDaddr_o;
    logic [31:0] RDdata_o;
    logic [2:0]  outstanding_o;

    int checks = 0;
    int errors = 0;
    logic allow_illegal = 1'b0;

    reg_wb_scheduler #(
        .MAX_OUT(4),
        .CNT_W(3),
        .STARVE_LIMIT(8),
        .WAIT_W(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .a_valid_i(a_valid_i),
        .a_addr_i(a_addr_i),
        .a_data_i(a_data_i),
        .b_valid_i(b_valid_i),
        .b_addr_i(b_addr_i),
        .b_data_i(b_data_i),
        .b_ready_o(b_ready_o),
        .issue_valid_i(issue_valid_i),
        .issue_rs_i(issue_rs_i),
        .issue_rt_i(issue_rt_i),
        .issue_rd_i(issue_rd_i),
        .issue_long_i(issue_long_i),
        .stall_o(stall_o),
        .RegWrite_o(RegWrite_o),
        .RDaddr_o(RDaddr_o),
        .RDdata_o(RDdata_o),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stimulus legality: a B accept needs an outstanding op on a busy register.
    always @(posedge clk_i) begin
        if (rst_i && b_valid_i && !a_valid_i && !allow_illegal) begin
            checks++;
            assert (outstanding_o != 3'd0 && (b_addr_i == 5'd0 || dut.busy[b_addr_i])) else begin
                errors++;
                $error("FAIL b_legal addr=%0d outstanding=%0d expected busy and nonzero",
                       b_addr_i, outstanding_o);
            end
        end
    end

    task automatic idle();
        a_valid_i     = 1'b0;
        a_addr_i      = 5'd0;
        a_data_i      = 32'd0;
        b_valid_i     = 1'b0;
        b_addr_i      = 5'd0;
        b_data_i      = 32'd0;
        issue_valid_i = 1'b0;
        issue_rs_i    = 5'd0;
        issue_rt_i    = 5'd0;
        issue_rd_i    = 5'd0;
        issue_long_i  = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk_i);
        idle();
    endtask

    task automatic at_pos();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic lng);
        issue_valid_i = 1'b1;
        issue_rs_i    = rs;
        issue_rt_i    = rt;
        issue_rd_i    = rd;
        issue_long_i  = lng;
    endtask

    initial begin
        rst_i = 1'b0;
        idle();
        #2;
        chk("rst_regwrite", 32'(RegWrite_o), 32'd0);
        chk("rst_addr", 32'(RDaddr_o), 32'd0);
        chk("rst_data", RDdata_o, 32'd0);
        chk("rst_out", 32'(outstanding_o), 32'd0);
        chk("rst_bready", 32'(b_ready_o), 32'd1);
        a_valid_i = 1'b1;
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        #1;
        chk("rst_bready_a", 32'(b_ready_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(negedge clk_i);
        idle();
        rst_i = 1'b1;

        // 1: A write r5
        at_neg();
        a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'h1234;
        #1 chk("t1_bready", 32'(b_ready_o), 32'd0);
        at_pos();
        chk("t1_we", 32'(RegWrite_o), 32'd1);
        chk("t1_addr", 32'(RDaddr_o), 32'd5);
        chk("t1_data", RDdata_o, 32'h1234);
        at_neg();
        at_pos();
        chk("t1_we_idle", 32'(RegWrite_o), 32'd0);
        chk("t1_addr_hold", 32'(RDaddr_o), 32'd5);
        chk("t1_data_hold", RDdata_o, 32'h1234);

        // 2: RAW on long op r8
        at_neg();
        issue(5'd1, 5'd2, 5'd8, 1'b1);
        #1 chk("t2_long_stall", 32'(stall_o), 32'd0);
        at_pos();
        chk("t2_out1", 32'(outstanding_o), 32'd1);
        at_neg();
        issue(5'd8, 5'd0, 5'd9, 1'b0);
        #1 chk("t2_raw_stall", 32'(stall_o), 32'd1);
        at_neg();
        issue(5'd8, 5'd0, 5'd9, 1'b0);
        b_valid_i = 1'b1; b_addr_i = 5'd8; b_data_i = 32'hBEEF;
        #1 chk("t2_bready", 32'(b_ready_o), 32'd1);
        chk("t2_no_bypass", 32'(stall_o), 32'd1);
        at_pos();
        chk("t2_b_we", 32'(RegWrite_o), 32'd1);
        chk("t2_b_addr", 32'(RDaddr_o), 32'd8);
        chk("t2_b_data", RDdata_o, 32'hBEEF);
        chk("t2_out0", 32'(outstanding_o), 32'd0);
        at_neg();
        issue(5'd8, 5'd0, 5'd9, 1'b0);
        #1 chk("t2_released", 32'(stall_o), 32'd0);
        at_pos();
        chk("t2_we_idle", 32'(RegWrite_o), 32'd0);

        // 3: outstanding limit
        for (int i = 1; i <= 4; i++) begin
            at_neg();
            issue(5'd0, 5'd0, 5'(i), 1'b1);
            #1 chk("t3_fill_stall", 32'(stall_o), 32'd0);
            at_pos();
        end
        chk("t3_out4", 32'(outstanding_o), 32'd4);
        at_neg();
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        #1 chk("t3_full_stall", 32'(stall_o), 32'd1);
        at_neg();
        issue(5'd10, 5'd0, 5'd10, 1'b0);
        #1 chk("t3_short_ok", 32'(stall_o), 32'd0);
        at_pos();
        chk("t3_out_still4", 32'(outstanding_o), 32'd4);

        // 4: B starvation under continuous A traffic
        for (int i = 0; i < 8; i++) begin
            at_neg();
            a_valid_i = 1'b1; a_addr_i = 5'd11; a_data_i = 32'(i);
            b_valid_i = 1'b1; b_addr_i = 5'd1; b_data_i = 32'hB1;
            issue(5'd12, 5'd13, 5'd12, 1'b0);
            #1 chk("t4_no_starve", 32'(stall_o), 32'd0);
            chk("t4_bready", 32'(b_ready_o), 32'd0);
            at_pos();
            chk("t4_a_addr", 32'(RDaddr_o), 32'd11);
        end
        at_neg();
        a_valid_i = 1'b1; a_addr_i = 5'd11; a_data_i = 32'h8;
        b_valid_i = 1'b1; b_addr_i = 5'd1; b_data_i = 32'hB1;
        issue(5'd12, 5'd13, 5'd12, 1'b0);
        #1 chk("t4_starve_on", 32'(stall_o), 32'd1);
        at_pos();
        at_neg();
        b_valid_i = 1'b1; b_addr_i = 5'd1; b_data_i = 32'hB1;
        issue(5'd12, 5'd13, 5'd12, 1'b0);
        #1 chk("t4_drain_bready", 32'(b_ready_o), 32'd1);
        chk("t4_drain_stall", 32'(stall_o), 32'd1);
        at_pos();
        chk("t4_b_we", 32'(RegWrite_o), 32'd1);
        chk("t4_b_addr", 32'(RDaddr_o), 32'd1);
        chk("t4_b_data", RDdata_o, 32'hB1);
        chk("t4_out3", 32'(outstanding_o), 32'd3);
        at_neg();
        issue(5'd12, 5'd13, 5'd12, 1'b0);
        #1 chk("t4_starve_off", 32'(stall_o), 32'd0);

        // 5: simultaneous long issue and B accept
        at_neg();
        issue(5'd0, 5'd0, 5'd5, 1'b1);
        b_valid_i = 1'b1; b_addr_i = 5'd2; b_data_i = 32'h22;
        #1 chk("t5_issue_ok", 32'(stall_o), 32'd0);
        at_pos();
        chk("t5_out_same", 32'(outstanding_o), 32'd3);
        chk("t5_b_addr", 32'(RDaddr_o), 32'd2);
        at_neg();
        issue(5'd2, 5'd0, 5'd0, 1'b0);
        #1 chk("t5_r2_free", 32'(stall_o), 32'd0);
        at_neg();
        issue(5'd5, 5'd0, 5'd0, 1'b0);
        #1 chk("t5_r5_busy", 32'(stall_o), 32'd1);
        at_neg();
        allow_illegal = 1'b1;
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        b_valid_i = 1'b1; b_addr_i = 5'd7; b_data_i = 32'h77;
        #1 chk("t5_collide_issue", 32'(stall_o), 32'd0);
        at_pos();
        allow_illegal = 1'b0;
        chk("t5_collide_out", 32'(outstanding_o), 32'd3);
        at_neg();
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        #1 chk("t5_set_wins", 32'(stall_o), 32'd1);
        at_neg();
        a_valid_i = 1'b1; a_addr_i = 5'd0; a_data_i = 32'hFFFF;
        at_pos();
        chk("t5_r0_we", 32'(RegWrite_o), 32'd0);
        chk("t5_r0_addr", 32'(RDaddr_o), 32'd0);

        // 6: asynchronous reset mid-stream
        at_neg();
        a_valid_i = 1'b1; a_addr_i = 5'd9; a_data_i = 32'h55;
        b_valid_i = 1'b1; b_addr_i = 5'd3; b_data_i = 32'h33;
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        #1 chk("t6_pre_stall", 32'(stall_o), 32'd1);
        at_pos();
        chk("t6_pre_we", 32'(RegWrite_o), 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_rst_we", 32'(RegWrite_o), 32'd0);
        chk("t6_rst_addr", 32'(RDaddr_o), 32'd0);
        chk("t6_rst_data", RDdata_o, 32'd0);
        chk("t6_rst_out", 32'(outstanding_o), 32'd0);
        chk("t6_rst_stall", 32'(stall_o), 32'd0);
        chk("t6_rst_bready", 32'(b_ready_o), 32'd0);
        at_neg();
        rst_i = 1'b1;
        issue(5'd7, 5'd4, 5'd3, 1'b0);
        #1 chk("t6_post_stall", 32'(stall_o), 32'd0);
        chk("t6_post_bready", 32'(b_ready_o), 32'd1);
        at_pos();
        chk("t6_post_we", 32'(RegWrite_o), 32'd0);
        at_neg();
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        #1 chk("t6_long_ok", 32'(stall_o), 32'd0);
        at_pos();
        chk("t6_out1", 32'(outstanding_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
